// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and helpers for the MIPS instruction-fetch PC stage:
// reset address, fetch state encoding, and redirect priority.
package mips_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        IDLE,
        REQ
    } fetch_state_e;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_BR,
        REDIR_J,
        REDIR_JR
    } redir_kind_e;

    // Register jumps outrank jumps, which outrank taken branches.
    function automatic redir_kind_e redirect_priority(
        input logic jr,
        input logic jump,
        input logic br_taken
    );
        redir_kind_e kind;
        if (jr) begin
            kind = REDIR_JR;
        end else if (jump) begin
            kind = REDIR_J;
        end else if (br_taken) begin
            kind = REDIR_BR;
        end else begin
            kind = REDIR_NONE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch PC stage
// (master) and the instruction memory (slave).
interface fetch_pc_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack
    );

endinterface

// File: rtl/fetch_pc_unit_branch_target_calc.sv
// Combinational redirect selector: picks the winning branch/jump/jr pulse,
// forms its target address and flags a misaligned register target.
module branch_target_calc
    import mips_fetch_pkg::*;
(
    input  logic        br_taken,
    input  logic [31:0] br_offset_sh,
    input  logic [31:0] br_base,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        redirect,
    output logic [31:0] target,
    output logic        misalign_err
);

    redir_kind_e kind;

    always_comb begin
        kind         = redirect_priority(jr, jump, br_taken);
        redirect     = (kind != REDIR_NONE);
        target       = br_base + br_offset_sh;
        misalign_err = 1'b0;
        case (kind)
            REDIR_JR: begin
                target       = {jr_target[31:2], 2'b00};
                misalign_err = (jr_target[1:0] != 2'b00);
            end
            REDIR_J:  target = {br_base[31:28], jump_index, 2'b00};
            default:  target = br_base + br_offset_sh;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC stage: issues req/ack fetches, applies redirects and
// delivers PC/PC+4 to decode. FETCH_DELAY_SLOT_EN enables MIPS delay slots.
module fetch_pc_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  br_taken,
    input  logic [31:0]           br_offset_sh,
    input  logic [31:0]           br_base,
    input  logic                  jump,
    input  logic [25:0]           jump_index,
    input  logic                  jr,
    input  logic [31:0]           jr_target,
    fetch_pc_unit_if.master       imem,
    output logic                  if_valid,
    output logic [31:0]           pc_out,
    output logic [31:0]           pc_plus4,
    output logic                  misalign_err
);

    fetch_state_e state, next_state;
    logic [31:0]  addr, next_addr;
    logic         pend_valid, next_pend_valid;
    logic [31:0]  pend_target, next_pend_target;
    logic         redirect;
    logic [31:0]  target;
    logic         squash;
    logic         deliver;

    branch_target_calc u_target (
        .br_taken     (br_taken),
        .br_offset_sh (br_offset_sh),
        .br_base      (br_base),
        .jump         (jump),
        .jump_index   (jump_index),
        .jr           (jr),
        .jr_target    (jr_target),
        .redirect     (redirect),
        .target       (target),
        .misalign_err (misalign_err)
    );

`ifdef FETCH_DELAY_SLOT_EN
    assign squash = 1'b0;
`else
    // An outstanding fetch is off-path once any redirect has been seen for it.
    assign squash = pend_valid | redirect;
`endif

    assign imem.imem_req  = (state == REQ);
    assign imem.imem_addr = addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state       = state;
        next_addr        = addr;
        next_pend_valid  = pend_valid;
        next_pend_target = pend_target;
        deliver          = 1'b0;
        case (state)
            BOOT: next_state = IDLE;
            IDLE: begin
                if (redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
                    next_pend_valid  = 1'b1;
                    next_pend_target = target;
`else
                    next_addr = target;
`endif
                end
                if (!stall) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (imem.imem_ack) begin
                    deliver         = !squash;
                    next_pend_valid = 1'b0;
                    if (redirect) begin
                        next_addr = target;
                    end else if (pend_valid) begin
                        next_addr = pend_target;
                    end else begin
                        next_addr = addr + 32'd4;
                    end
                    next_state = stall ? IDLE : REQ;
                end else if (redirect) begin
                    next_pend_valid  = 1'b1;
                    next_pend_target = target;
                end
            end
            default: next_state = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr        <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
            if_valid    <= 1'b0;
            pc_out      <= 32'd0;
            pc_plus4    <= 32'd0;
        end else begin
            addr        <= next_addr;
            pend_valid  <= next_pend_valid;
            pend_target <= next_pend_target;
            if_valid    <= deliver;
            if (deliver) begin
                pc_out   <= addr;
                pc_plus4 <= addr + 32'd4;
            end
        end
    end

endmodule
